saida_display: RTL and testbench

Output-side peripheral for the MIPS processor board: the processor's display path, the counterpart to the switch/button input block. It captures a 32-bit two's-complement value written by the processor's output instruction and converts it to decimal with a sequential double-dabble engine (one bit per clock). It drives eight active-low seven-segment displays: sign on HEX7, seven magnitude digits on HEX6..HEX0. A busy flag and a one-deep pending slot let the processor write at any time without losing the most recent value.

---
 rtl/saida_display.sv | 172 +++++++++++++++++
 tb/tb_saida_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/saida_display.sv
// saida_display: captures a signed 32-bit value, converts its magnitude to BCD
// with a one-bit-per-clock double-dabble engine and drives eight active-low
// seven-segment displays (sign on HEX7, seven digits on HEX6..HEX0).
module saida_display #(
  parameter int unsigned ZERO_BLANK = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        EscreveSaida,
  input  logic [31:0] DadoSaida,
  output logic        Ocupado,
  output logic [31:0] ValorExibido,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  localparam int unsigned DW   = 32;
  localparam int unsigned BCDW = 40;
  localparam int unsigned NDIG = 7;
  localparam int unsigned NHEX = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} state_t;

  state_t            state_q;
  logic [DW-1:0]     bin_q;
  logic [BCDW-1:0]   bcd_q;
  logic [4:0]        cnt_q;
  logic              neg_q;
  logic [DW-1:0]     val_q;
  logic              pend_q;
  logic [DW-1:0]     pend_val_q;
  logic              busy_q;
  logic [DW-1:0]     shown_q;
  logic [6:0]        hex_q [NHEX];

  logic [BCDW-1:0]   bcd_adj;
  logic [BCDW-1:0]   bcd_d;
  logic [DW-1:0]     bin_d;
  logic [DW-1:0]     load_val;
  logic [DW-1:0]     load_mag;
  logic              ovf;
  logic              seen;
  logic [3:0]        dig;
  logic [6:0]        hex_d [NHEX];

  // Digit to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Value to load: a fresh strobe wins over the pending slot
  always_comb begin
    load_val = EscreveSaida ? DadoSaida : pend_val_q;
    load_mag = load_val[DW-1] ? (32'd0 - load_val) : load_val;
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BCDW-2:0], bin_q[DW-1]};
    bin_d = {bin_q[DW-2:0], 1'b0};
  end

  // Display image built from the finished BCD result
  always_comb begin
    for (int i = 0; i < int'(NHEX); i++) hex_d[i] = SEG_BLANK;
    seen = 1'b0;
    dig  = 4'd0;
    ovf  = |bcd_q[BCDW-1:28];
    if (ovf) begin
      hex_d[0] = SEG_E;
    end else begin
      for (int i = int'(NDIG) - 1; i >= 0; i--) begin
        dig = bcd_q[4*i +: 4];
        if (dig != 4'd0) seen = 1'b1;
        if ((ZERO_BLANK != 0) && !seen && (i != 0)) hex_d[i] = SEG_BLANK;
        else hex_d[i] = seg7(dig);
      end
    end
    hex_d[7] = neg_q ? SEG_DASH : SEG_BLANK;
  end

  // Control FSM, conversion datapath, pending slot and registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= OCIOSO;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      val_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      shown_q    <= '0;
      for (int i = 0; i < int'(NHEX); i++) hex_q[i] <= SEG_BLANK;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (EscreveSaida || pend_q) begin
            val_q   <= load_val;
            neg_q   <= load_val[DW-1];
            bin_q   <= load_mag;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= ATUALIZA;
          if (EscreveSaida) begin
            pend_q     <= 1'b1;
            pend_val_q <= DadoSaida;
          end
        end
        ATUALIZA: begin
          for (int i = 0; i < int'(NHEX); i++) hex_q[i] <= hex_d[i];
          shown_q <= val_q;
          busy_q  <= 1'b0;
          state_q <= OCIOSO;
          if (EscreveSaida) begin
            pend_q     <= 1'b1;
            pend_val_q <= DadoSaida;
          end
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign Ocupado      = busy_q;
  assign ValorExibido = shown_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_saida_display.sv
// Bench for saida_display: table of written values with hand-computed segment
// images for both ZERO_BLANK settings, plus pending and reset sequences.
module tb_saida_display;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D  = 7'b0111111;
  localparam logic [6:0] E  = 7'b0000110;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] data;

  logic        busy_a, busy_b;
  logic [31:0] val_a, val_b;
  logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
  logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  saida_display #(.ZERO_BLANK(1)) dut_a (
    .Clock(clk), .Reset(rst), .EscreveSaida(wr), .DadoSaida(data),
    .Ocupado(busy_a), .ValorExibido(val_a),
    .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3),
    .HEX4(a4), .HEX5(a5), .HEX6(a6), .HEX7(a7)
  );

  saida_display #(.ZERO_BLANK(0)) dut_b (
    .Clock(clk), .Reset(rst), .EscreveSaida(wr), .DadoSaida(data),
    .Ocupado(busy_b), .ValorExibido(val_b),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3),
    .HEX4(b4), .HEX5(b5), .HEX6(b6), .HEX7(b7)
  );

  wire [55:0] hex_a = {a7, a6, a5, a4, a3, a2, a1, a0};
  wire [55:0] hex_b = {b7, b6, b5, b4, b3, b2, b1, b0};

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [55:0] ha;
    logic [55:0] hb;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Strobe one value so that it is sampled at the next rising edge (T0)
  task automatic strobe(input logic [31:0] v);
    @(negedge clk);
    data = v;
    wr   = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  initial begin
    logic [31:0] prev_val;
    int          busy_bad;
    logic        saw8;

    vecs[0] = '{"w1234", 32'd1234,
                {B, B, B, B, S1, S2, S3, S4}, {B, S0, S0, S0, S1, S2, S3, S4}};
    vecs[1] = '{"wm56", 32'hFFFF_FFC8,
                {D, B, B, B, B, B, S5, S6}, {D, S0, S0, S0, S0, S0, S5, S6}};
    vecs[2] = '{"w0", 32'd0,
                {B, B, B, B, B, B, B, S0}, {B, S0, S0, S0, S0, S0, S0, S0}};
    vecs[3] = '{"w10M", 32'd10_000_000,
                {B, B, B, B, B, B, B, E}, {B, B, B, B, B, B, B, E}};
    vecs[4] = '{"wmin", 32'h8000_0000,
                {D, B, B, B, B, B, B, E}, {D, B, B, B, B, B, B, E}};
    vecs[5] = '{"w9999999", 32'd9_999_999,
                {B, S9, S9, S9, S9, S9, S9, S9}, {B, S9, S9, S9, S9, S9, S9, S9}};
    vecs[6] = '{"wm1", 32'hFFFF_FFFF,
                {D, B, B, B, B, B, B, S1}, {D, S0, S0, S0, S0, S0, S0, S1}};

    rst  = 1'b1;
    wr   = 1'b0;
    data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hex", 64'(hex_a), 64'({8{B}}));
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_val", 64'(val_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    prev_val = 32'd0;
    for (int v = 0; v < 7; v++) begin
      strobe(vecs[v].val);
      busy_bad = 0;
      for (int c = 1; c <= 32; c++) begin
        if (busy_a !== 1'b1) busy_bad++;
        @(posedge clk);
        #1;
      end
      chk({vecs[v].name, "_busy32"}, 64'(busy_bad), 64'd0);
      chk({vecs[v].name, "_hold"}, 64'(val_a), 64'(prev_val));
      @(posedge clk);
      #1;
      chk({vecs[v].name, "_done"}, 64'(busy_a), 64'd0);
      chk({vecs[v].name, "_val"}, 64'(val_a), 64'(vecs[v].val));
      chk({vecs[v].name, "_hexzb1"}, 64'(hex_a), 64'(vecs[v].ha));
      chk({vecs[v].name, "_hexzb0"}, 64'(hex_b), 64'(vecs[v].hb));
      prev_val = vecs[v].val;
      repeat (2) @(posedge clk);
    end

    // Pending: 7 converts, 8 is overwritten by 9, which converts next
    strobe(32'd7);
    saw8 = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      if (c == 5)  begin data = 32'd8; wr = 1'b1; end
      if (c == 10) begin data = 32'd9; wr = 1'b1; end
      @(posedge clk);
      #1;
      wr = 1'b0;
      if (val_a == 32'd8) saw8 = 1'b1;
      if (c == 33) begin
        chk("pend_val7", 64'(val_a), 64'd7);
        chk("pend_hex7", 64'(hex_a), 64'({B, B, B, B, B, B, B, S7}));
        chk("pend_gap", 64'(busy_a), 64'd0);
      end
      if (c == 34) chk("pend_reload", 64'(busy_a), 64'd1);
      if (c == 66) chk("pend_hold7", 64'(val_a), 64'd7);
      if (c == 67) begin
        chk("pend_val9", 64'(val_a), 64'd9);
        chk("pend_hex9", 64'(hex_a), 64'({B, B, B, B, B, B, B, S9}));
        chk("pend_busy", 64'(busy_a), 64'd0);
      end
    end
    chk("pend_no8", 64'(saw8), 64'd0);

    // Asynchronous reset in the middle of converting 42, with a pending value
    repeat (2) @(posedge clk);
    strobe(32'd42);
    repeat (14) @(posedge clk);
    #1;
    data = 32'd77;
    wr   = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hex", 64'(hex_a), 64'({8{B}}));
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_val", 64'(val_a), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    busy_bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (busy_a !== 1'b0 || val_a !== 32'd0 || hex_a !== {8{B}}) busy_bad++;
    end
    chk("arst_quiet", 64'(busy_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
